obf_key_loader: RTL and testbench
=================================

Name: obf_key_loader

Overview:
- Serial configuration controller for camouflaged-gate sites in obfuscated ISCAS netlists (c432 family).
- Each site takes a 2-bit select code: 00 = pass-through, 01 = invert, 10 = constant 1, 11 = constant 0.
- The block shifts in a key with a valid/ready handshake, checks its parity, and applies it atomically to the D_* select inputs.
- It then waits a settle window before flagging the netlist as usable, and can optionally lock the key until reset.

Parameters:
- NUM_SITES, 2, number of obfuscated sites driven.
- KEY_W, 2*NUM_SITES, key width in bits (derived; not overridden independently).
- SETTLE_CYC, 3, cycles between key_out update and cfg_done (combinational settle of the obfuscated datapath); minimum 1.
- RESET_KEY, {KEY_W{1'b0}}, value of key_out after reset (all sites pass-through).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a key load.
- key_bit  in  1  serial key/parity data.
- key_valid  in  1  key_bit is valid this cycle.
- key_ready  out  1  loader accepts key_bit this cycle.
- lock_req  in  1  sampled in DONE; if 1, enter LOCKED.
- key_out  out  KEY_W  applied key; bit 2i drives D_2i, bit 2i+1 drives D_2i+1.
- cfg_done  out  1  applied key has settled and the netlist output is usable.
- busy  out  1  a load is in progress (not IDLE and not LOCKED).
- err  out  1  sticky parity-failure flag.
- locked  out  1  key is frozen until reset.

Behaviour:
- Reset (async assert; sampled deassert): state = IDLE, key_out = RESET_KEY, shadow = 0, counters = 0, and key_ready, cfg_done, busy, err, locked all 0.
- A beat transfers when key_valid && key_ready on a rising edge.
- FSM states: IDLE, SHIFT, PARITY, SETTLE, DONE, LOCKED.
- IDLE:
  - load_start = 1 -> SHIFT; clear bit counter, err and cfg_done.
  - key_ready = 0.
- SHIFT:
  - key_ready = 1.
  - Data is LSB-first: beat k writes shadow[k], for k = 0..KEY_W-1.
  - After beat KEY_W-1 -> PARITY.
  - No beat in a cycle means stay; no timeout.
- PARITY:
  - key_ready = 1; accept one beat p.
  - Pass when the XOR of shadow and p is 0 (even parity over KEY_W+1 bits).
  - Pass: on that same edge key_out <= shadow -> SETTLE, settle counter = 0.
  - Fail: err <= 1, key_out unchanged, cfg_done stays 0 -> IDLE.
- SETTLE:
  - Counts SETTLE_CYC cycles, then -> DONE.
  - key_out is stable throughout.
- DONE (one cycle):
  - cfg_done <= 1 on entry.
  - lock_req = 1 -> LOCKED, else -> IDLE.
  - cfg_done stays 1 in IDLE until the next accepted load_start.
- LOCKED:
  - Terminal until reset. locked = 1, cfg_done = 1, key_ready = 0.
  - load_start is ignored.
- busy = 1 in SHIFT, PARITY, SETTLE and DONE.
- load_start outside IDLE is ignored; it does not restart a load.
- key_valid while key_ready = 0 is ignored; no data is captured.
- key_out changes only on a parity-pass edge or on reset. Partial loads never reach key_out.
- Reset mid-load discards the shadow and returns key_out to RESET_KEY.
- err persists through IDLE until the next accepted load_start.
- Timing: cfg_done rises SETTLE_CYC+1 edges after the edge that updates key_out.

Test Plan:
- Reset, then load bits 1,0,0,1 followed by parity 0:
  - key_out = 4'b1001 on the parity edge.
  - cfg_done = 1 four edges later.
  - busy = 0 and err = 0 afterwards.
- Load bits 1,1,1,0 followed by parity 0 (odd total):
  - err = 1 and key_out keeps its prior value.
  - cfg_done = 0; state returns to IDLE.
- During SHIFT, drop key_valid for 5 cycles and pulse load_start mid-load:
  - Load completes with the correct key; the pulse has no effect.
- Successful load of 4'b0110 with lock_req = 1 in DONE:
  - locked = 1 and cfg_done = 1.
  - A later load_start with a new key leaves key_out = 4'b0110 and key_ready = 0.
- Assert rst_n = 0 after the second data beat of a load over an applied key 4'b1111:
  - key_out = 4'b0000 immediately (async); all flags 0.
  - A fresh load then succeeds.
- Back-to-back: complete a load, then issue load_start the cycle after returning to IDLE:
  - cfg_done drops on that edge.
  - The second key applies correctly.

Source files
------------

// File: rtl/obf_key_loader.sv
// Serial key loader for camouflaged-gate select inputs.
// The key is shifted in LSB-first, parity checked, then applied atomically.
module obf_key_loader #(
   parameter int              NUM_SITES  = 2,
   parameter int              KEY_W      = 2 * NUM_SITES,
   parameter int              SETTLE_CYC = 3,
   parameter logic [KEY_W-1:0] RESET_KEY = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             key_bit,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             lock_req,
   output logic [KEY_W-1:0] key_out,
   output logic             cfg_done,
   output logic             busy,
   output logic             err,
   output logic             locked
);

   localparam int BW = $clog2(KEY_W + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      PARITY,
      SETTLE,
      DONE,
      LOCKED
   } state_t;

   state_t           state;
   state_t           state_d;
   logic [KEY_W-1:0] shadow;
   logic [BW-1:0]    bit_cnt;
   logic [SW-1:0]    set_cnt;
   logic             beat;
   logic             par_ok;

   assign beat   = key_valid && key_ready;
   assign par_ok = ~(^shadow ^ key_bit);

   always_comb begin
      key_ready = (state == SHIFT) || (state == PARITY);
      busy      = (state == SHIFT) || (state == PARITY)
               || (state == SETTLE) || (state == DONE);
      locked    = (state == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:   if (load_start) state_d = SHIFT;
         SHIFT:  if (beat && bit_cnt == BW'(KEY_W - 1)) state_d = PARITY;
         PARITY: if (beat) state_d = par_ok ? SETTLE : IDLE;
         SETTLE: if (set_cnt == SW'(SETTLE_CYC - 1)) state_d = DONE;
         DONE:   state_d = lock_req ? LOCKED : IDLE;
         LOCKED: state_d = LOCKED;
         default: state_d = IDLE;
      endcase
   end

   // Shadow is cleared on start so beats can be OR-ed in by position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_out  <= RESET_KEY;
         shadow   <= '0;
         bit_cnt  <= '0;
         set_cnt  <= '0;
         cfg_done <= 1'b0;
         err      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_start) begin
                  shadow   <= '0;
                  bit_cnt  <= '0;
                  err      <= 1'b0;
                  cfg_done <= 1'b0;
               end
            end
            SHIFT: begin
               if (beat) begin
                  shadow  <= shadow | (KEY_W'(key_bit) << bit_cnt);
                  bit_cnt <= bit_cnt + BW'(1);
               end
            end
            PARITY: begin
               if (beat) begin
                  if (par_ok) begin
                     key_out <= shadow;
                     set_cnt <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SETTLE: set_cnt <= set_cnt + SW'(1);
            DONE:   cfg_done <= 1'b1;
            LOCKED: cfg_done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obf_key_loader.sv
// Bench for obf_key_loader: table vectors, corner sequences and
// randomized loads against a transaction-level key model.
module tb_obf_key_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_start = 1'b0;
   logic       key_bit = 1'b0;
   logic       key_valid = 1'b0;
   logic       lock_req = 1'b0;
   logic       key_ready;
   logic [3:0] key_out;
   logic       cfg_done;
   logic       busy;
   logic       err;
   logic       locked;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   obf_key_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .key_bit    (key_bit),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .lock_req   (lock_req),
      .key_out    (key_out),
      .cfg_done   (cfg_done),
      .busy       (busy),
      .err        (err),
      .locked     (locked)
   );

   typedef struct {
      logic [3:0] k;
      logic       p;
      logic       lk;
      logic [3:0] ek;
      logic       ee;
      logic       ed;
      logic       el;
   } vec_t;

   vec_t vt[6];

   logic [3:0] m_key;
   logic       m_err;
   logic       m_done;
   logic       m_lock;

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_key = 4'b0; m_err = 0; m_done = 0; m_lock = 0;
   endtask

   task automatic send_beat(input logic b);
      int n = 0;
      while (!key_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!key_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      key_valid = 1'b1;
      key_bit   = b;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic do_load(input logic [3:0] k, input logic p,
                          input logic lk, input int gap,
                          input bit pulse, input bit chk_drop,
                          output logic [3:0] kedge, output int lat);
      lock_req   = lk;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      if (chk_drop) chk("cfg_drop", cfg_done, 0);
      for (int i = 0; i < 4; i++) begin
         send_beat(k[i]);
         if (i == 1) begin
            for (int g = 0; g < gap; g++) begin
               load_start = pulse && (g == 2);
               @(negedge clk);
            end
            load_start = 1'b0;
         end
      end
      send_beat(p);
      kedge = key_out;
      lat = 0;
      while (busy && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (busy) chk("busy_timeout", 1, 0);
      lock_req = 1'b0;
   endtask

   task automatic model_load(input logic [3:0] k, input logic p,
                             input logic lk, output bit pass);
      pass = 0;
      if (m_lock) return;
      if (((^k) ^ p) == 1'b0) begin
         pass = 1;
         m_key = k; m_err = 0; m_done = 1; m_lock = lk;
      end else begin
         m_err = 1; m_done = 0;
      end
   endtask

   task automatic chk_model(input string t);
      chk({t, ".key"}, key_out, m_key);
      chk({t, ".err"}, err, m_err);
      chk({t, ".done"}, cfg_done, m_done);
      chk({t, ".lock"}, locked, m_lock);
      chk({t, ".busy"}, busy, 0);
   endtask

   task automatic try_locked(input logic [3:0] k);
      int rdy = 0;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         key_valid = 1'b1;
         key_bit   = k[i % 4];
         @(negedge clk);
         rdy += int'(key_ready);
      end
      key_valid = 1'b0;
      chk("locked.ready", rdy, 0);
   endtask

   logic [3:0] ke;
   int         lat;
   bit         pass;

   initial begin
      vt[0] = '{4'b1001, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0};
      vt[1] = '{4'b1110, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0};
      vt[2] = '{4'b1110, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b1, 1'b0};
      vt[3] = '{4'b0000, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0};
      vt[4] = '{4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0};
      vt[5] = '{4'b0110, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst.key", key_out, 0);
      chk("rst.ready", key_ready, 0);
      chk("rst.done", cfg_done, 0);
      chk("rst.busy", busy, 0);
      chk("rst.err", err, 0);
      chk("rst.lock", locked, 0);
      rst_n = 1'b1;
      m_key = 4'b0; m_err = 0; m_done = 0; m_lock = 0;

      for (int i = 0; i < 6; i++) begin
         do_load(vt[i].k, vt[i].p, vt[i].lk, 0, 0, 0, ke, lat);
         chk($sformatf("vec%0d.key", i), key_out, vt[i].ek);
         chk($sformatf("vec%0d.err", i), err, vt[i].ee);
         chk($sformatf("vec%0d.done", i), cfg_done, vt[i].ed);
         chk($sformatf("vec%0d.lock", i), locked, vt[i].el);
         chk($sformatf("vec%0d.busy", i), busy, 0);
         if (vt[i].ed) begin
            chk($sformatf("vec%0d.kedge", i), ke, vt[i].ek);
            chk($sformatf("vec%0d.lat", i), lat, 4);
         end
      end

      try_locked(4'b1001);
      chk("locked.key", key_out, 4'b0110);
      chk("locked.flag", locked, 1);
      chk("locked.done", cfg_done, 1);

      reset_dut();
      do_load(4'b1011, 1'b1, 1'b0, 5, 1, 0, ke, lat);
      chk("gap.key", key_out, 4'b1011);
      chk("gap.err", err, 0);
      chk("gap.lat", lat, 4);

      do_load(4'b1111, 1'b0, 1'b0, 0, 0, 0, ke, lat);
      chk("pre_rst.key", key_out, 4'b1111);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      send_beat(1'b0);
      send_beat(1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst.key", key_out, 0);
      chk("midrst.done", cfg_done, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.err", err, 0);
      chk("midrst.lock", locked, 0);
      chk("midrst.ready", key_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_key = 4'b0; m_err = 0; m_done = 0; m_lock = 0;
      do_load(4'b0011, 1'b0, 1'b0, 0, 0, 0, ke, lat);
      chk("fresh.key", key_out, 4'b0011);
      chk("fresh.done", cfg_done, 1);

      do_load(4'b1100, 1'b0, 1'b0, 0, 0, 0, ke, lat);
      chk("b2b1.key", key_out, 4'b1100);
      do_load(4'b0001, 1'b1, 1'b0, 0, 0, 1, ke, lat);
      chk("b2b2.key", key_out, 4'b0001);
      chk("b2b2.lat", lat, 4);

      reset_dut();
      for (int r = 0; r < 40; r++) begin
         logic [3:0] k;
         logic       p;
         logic       lk;
         k  = 4'($urandom);
         p  = 1'($urandom);
         lk = ($urandom_range(0, 7) == 0);
         do_load(k, p, lk, int'($urandom_range(0, 3)), 0, 0, ke, lat);
         model_load(k, p, lk, pass);
         chk_model($sformatf("rnd%0d", r));
         if (pass) begin
            chk($sformatf("rnd%0d.kedge", r), ke, k);
            chk($sformatf("rnd%0d.lat", r), lat, 4);
         end
         if (m_lock) begin
            try_locked(4'($urandom));
            chk($sformatf("rnd%0d.lkey", r), key_out, m_key);
            reset_dut();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
